// File: rtl/shift_readback_packer.sv
`timescale 1ns/1ps
// Shift-chain readback: pulses SHIFT_ENABLE per bit, packs SHIFT_TAIL LSB-first into bytes,
// and hands each byte to the UART over valid/ready. Optional macro: READBACK_RECIRC_EN.
module shift_readback_packer #(
  parameter int   COUNT_W   = 16,
  parameter logic HEAD_FILL = 1'b0
) (
  input  logic               SCLK,
  input  logic               RESET,
  input  logic               START,
  input  logic [COUNT_W-1:0] BIT_COUNT,
  input  logic               SHIFT_TAIL,
  output logic               SHIFT_ENABLE,
  output logic               SHIFT_HEAD,
  input  logic               UART_READY,
  output logic               TX_VALID,
  output logic [7:0]         TX_DATA,
  output logic               BUSY,
  output logic               DONE
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    SEND   = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t             state_reg;
  logic [COUNT_W-1:0] remaining_reg;
  logic [2:0]         idx_reg;
  logic [7:0]         byte_reg;
  logic [7:0]         byte_next;
  logic               shift_enable_reg;
  logic               tx_valid_reg;
  logic [7:0]         tx_data_reg;
  logic               busy_reg;
  logic               done_reg;

  // Byte with the current tail bit dropped into position idx; other bits keep their value.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_capture
      assign byte_next[gi] = (idx_reg == 3'(gi)) ? SHIFT_TAIL : byte_reg[gi];
    end
  endgenerate

  always_ff @(posedge SCLK) begin
    if (RESET) begin
      state_reg        <= IDLE;
      remaining_reg    <= '0;
      idx_reg          <= '0;
      byte_reg         <= '0;
      shift_enable_reg <= 1'b0;
      tx_valid_reg     <= 1'b0;
      tx_data_reg      <= 8'h00;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (START) begin
            remaining_reg <= BIT_COUNT;
            idx_reg       <= '0;
            byte_reg      <= '0;
            busy_reg      <= 1'b1;
            if (BIT_COUNT == '0) begin
              state_reg <= FINISH;
            end else begin
              state_reg        <= SHIFT;
              shift_enable_reg <= 1'b1;
            end
          end
        end
        SHIFT: begin
          byte_reg      <= byte_next;
          idx_reg       <= idx_reg + 3'd1;
          remaining_reg <= remaining_reg - COUNT_W'(1);
          if (idx_reg == 3'd7 || remaining_reg == COUNT_W'(1)) begin
            // byte_reg was cleared on entry, so bits not yet filled are already zero
            state_reg        <= SEND;
            shift_enable_reg <= 1'b0;
            tx_valid_reg     <= 1'b1;
            tx_data_reg      <= byte_next;
          end
        end
        SEND: begin
          if (UART_READY) begin
            tx_valid_reg <= 1'b0;
            if (remaining_reg != '0) begin
              state_reg        <= SHIFT;
              shift_enable_reg <= 1'b1;
              idx_reg          <= '0;
              byte_reg         <= '0;
            end else begin
              state_reg <= FINISH;
            end
          end
        end
        FINISH: begin
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign SHIFT_ENABLE = shift_enable_reg;
  assign TX_VALID     = tx_valid_reg;
  assign TX_DATA      = tx_data_reg;
  assign BUSY         = busy_reg;
  assign DONE         = done_reg;

`ifdef READBACK_RECIRC_EN
  // Feed the tail back into the head so a full-length read leaves the chain intact.
  assign SHIFT_HEAD = shift_enable_reg ? SHIFT_TAIL : HEAD_FILL;
`else
  assign SHIFT_HEAD = HEAD_FILL;
`endif

endmodule
